mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with the ports listed below.
REQ-002 The block SHALL use the port `CLK`: input, 1 bit, clock; all state is updated on its rising edge.
REQ-003 The block SHALL use the port `RESET`: input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL use the port `DATA1`: input, 32 bits, operand rs1 (the output of operand mux 1).
REQ-005 The block SHALL use the port `DATA2`: input, 32 bits, operand rs2 (the output of operand mux 2).
REQ-006 The block SHALL use the port `FUNC`: input, 3 bits, RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 The block SHALL use the port `START`: input, 1 bit, request to begin an operation.
REQ-008 The block SHALL use the port `FLUSH`: input, 1 bit, synchronous abort of the operation in flight.
REQ-009 The block SHALL use the port `RESULT`: output, 32 bits, registered result.
REQ-010 The block SHALL use the port `BUSY`: output, 1 bit, operation in progress; the pipeline stalls on it.
REQ-011 The block SHALL use the port `DONE`: output, 1 bit, one-cycle pulse marking `RESULT` valid.

Function
REQ-012 The FSM SHALL have states IDLE, CALC, FIX and DONE_ST, with the transitions defined in REQ-013 to REQ-016.
REQ-013 In IDLE, a START=1 at edge t0 SHALL:
- latch `FUNC`;
- latch the operand magnitudes and the sign flags, per the signedness of `FUNC`;
- load a 5-bit counter with 31;
- set BUSY=1;
- move to CALC.
REQ-014 CALC SHALL perform one iteration per edge for exactly 32 edges (t1..t32):
- the counter decrements each edge;
- at counter=0 the FSM moves to FIX.
REQ-015 Multiply SHALL use radix-2 shift-add into a 64-bit product register; divide SHALL use radix-2 restoring division with a 32-bit quotient and a 33-bit partial remainder.
REQ-016 At edge t33, FIX SHALL:
- apply the sign correction;
- apply the special-case overrides;
- register `RESULT`;
- set DONE=1 and BUSY=0;
- move to DONE_ST.
REQ-017 At edge t34, DONE_ST SHALL clear DONE and return to IDLE; a START seen in DONE_ST SHALL be ignored.
REQ-018 Latency SHALL be fixed at 33 cycles from the START edge to DONE for every FUNC and operand value, including the special cases.
REQ-019 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32], with signed×signed, signed×unsigned and unsigned×unsigned operand interpretation respectively.
REQ-020 The 64-bit product SHALL be negated when exactly one interpreted-signed operand is negative.
REQ-021 For signed divide, the quotient sign SHALL be sign(DATA1) XOR sign(DATA2), and the remainder sign SHALL equal sign(DATA1).
REQ-022 Division by zero SHALL return 0xFFFFFFFF for DIV and DIVU, and DATA1 for REM and REMU.
REQ-023 Signed overflow (DATA1=0x80000000, DATA2=0xFFFFFFFF) SHALL return 0x80000000 for DIV and 0x00000000 for REM.
REQ-024 START while BUSY=1 SHALL be ignored, and the operands SHALL NOT be re-sampled mid-operation.
REQ-025 FLUSH=1 in any state SHALL, at the next edge, force IDLE with BUSY=0 and DONE=0, and SHALL leave `RESULT` unchanged.
REQ-026 When FLUSH and START are both 1 in IDLE, FLUSH SHALL win and no operation SHALL start.
REQ-027 `RESULT` SHALL hold its last value until the next FIX.
REQ-028 `RESULT` SHALL change only at the FIX edge.

Reset
REQ-029 While RESET=0, asynchronously and regardless of `CLK`, the block SHALL force IDLE, RESULT=0x00000000, BUSY=0, DONE=0, counter=0 and all internal registers to 0.
REQ-030 Reset asserted mid-operation SHALL discard the operation, and no DONE SHALL follow.
REQ-031 The first START SHALL be accepted on the first rising edge after RESET returns to 1.

Verification
REQ-032 The bench SHALL cover MUL: DATA1=7, DATA2=0xFFFFFFFD (-3), START at t0 -> BUSY=1 for t0..t32, DONE=1 at t33, RESULT=0xFFFFFFEB.
REQ-033 The bench SHALL cover MULH: DATA1=DATA2=0x80000000 -> RESULT=0x40000000 at t33; the same operands with MULHU -> RESULT=0x40000000; with MULHSU -> RESULT=0xC0000000.
REQ-034 The bench SHALL cover divide by zero: DIVU 100/0 -> RESULT=0xFFFFFFFF; REMU 100/0 -> RESULT=0x00000064; both at t33.
REQ-035 The bench SHALL cover signed divide: DIV -7/2 -> RESULT=0xFFFFFFFD (-3); REM -7/2 -> RESULT=0xFFFFFFFF (-1); DIV 0x80000000/0xFFFFFFFF -> RESULT=0x80000000; REM with the same operands -> RESULT=0.
REQ-036 The bench SHALL cover flush: START DIVU at t0, FLUSH=1 at t10 -> BUSY=0 after t10, no DONE, RESULT unchanged; then START at t12 -> DONE at t45.
REQ-037 The bench SHALL cover reset and ignored START:
- RESET=0 mid-CALC -> outputs are 0 immediately;
- START=1 pulsed every cycle during BUSY -> only one DONE, and its RESULT matches the first operands.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// fixed 33-cycle latency from the START edge to the DONE pulse.
module mul_div_unit (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] DATA1,
   input  logic [31:0] DATA2,
   input  logic [2:0]  FUNC,
   input  logic        START,
   input  logic        FLUSH,
   output logic [31:0] RESULT,
   output logic        BUSY,
   output logic        DONE
);

   // Handshake: START is taken only in IDLE (and not with FLUSH); BUSY is high from the
   // accepting edge until the FIX edge; DONE is a one-cycle pulse with RESULT valid.
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE_ST} state_t;

   state_t      state, state_nxt;
   logic [4:0]  cnt;
   logic [2:0]  func_q;
   logic [31:0] mag_a, mag_b;
   logic        sign_a, sign_b, div_zero, ovf;
   logic [63:0] prod;
   logic [31:0] rem;
   logic [31:0] quo;

   // operand interpretation at START
   logic        is_div, a_signed, b_signed, in_sa, in_sb, accept;
   logic [31:0] in_mag_a, in_mag_b;

   always_comb begin
      is_div   = FUNC[2];
      a_signed = is_div ? ~FUNC[0] : (FUNC[1:0] != 2'b11);
      b_signed = is_div ? ~FUNC[0] : ~FUNC[1];
      in_sa    = a_signed & DATA1[31];
      in_sb    = b_signed & DATA2[31];
      in_mag_a = in_sa ? (~DATA1 + 32'd1) : DATA1;
      in_mag_b = in_sb ? (~DATA2 + 32'd1) : DATA2;
      accept   = (state == IDLE) && START && !FLUSH;
   end

   // one iteration of each algorithm
   logic [32:0] mul_sum, rem_sh, rem_sub;
   logic [63:0] prod_nxt;
   logic        rem_ge;

   always_comb begin
      mul_sum  = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mag_a} : 33'd0);
      prod_nxt = {mul_sum, prod[31:1]};
      rem_sh   = {rem, quo[31]};
      rem_sub  = rem_sh - {1'b0, mag_b};
      rem_ge   = (rem_sh >= {1'b0, mag_b});
   end

   // sign correction and special-case overrides
   logic [63:0] prod_s;
   logic [31:0] quo_s, rem_s, a_orig, fix_res;

   always_comb begin
      prod_s  = (sign_a ^ sign_b) ? -prod : prod;
      quo_s   = (sign_a ^ sign_b) ? -quo : quo;
      rem_s   = sign_a ? -rem : rem;
      a_orig  = sign_a ? -mag_a : mag_a;
      fix_res = prod_s[31:0];
      case (func_q)
         3'b000:                 fix_res = prod_s[31:0];
         3'b001, 3'b010, 3'b011: fix_res = prod_s[63:32];
         3'b100, 3'b101:         fix_res = div_zero ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : quo_s);
         default:                fix_res = div_zero ? a_orig : (ovf ? 32'h0000_0000 : rem_s);
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      BUSY      = 1'b0;
      DONE      = 1'b0;
      case (state)
         IDLE:    if (accept) state_nxt = CALC;
         CALC:    begin
                     BUSY = 1'b1;
                     if (cnt == 5'd0) state_nxt = FIX;
                  end
         FIX:     begin
                     BUSY      = 1'b1;
                     state_nxt = DONE_ST;
                  end
         DONE_ST: begin
                     DONE      = 1'b1;
                     state_nxt = IDLE;
                  end
         default: state_nxt = IDLE;
      endcase
      if (FLUSH) state_nxt = IDLE;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         cnt      <= 5'd0;
         func_q   <= 3'd0;
         mag_a    <= 32'd0;
         mag_b    <= 32'd0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         div_zero <= 1'b0;
         ovf      <= 1'b0;
         prod     <= 64'd0;
         rem      <= 32'd0;
         quo      <= 32'd0;
         RESULT   <= 32'd0;
      end else if (accept) begin
         cnt      <= 5'd31;
         func_q   <= FUNC;
         mag_a    <= in_mag_a;
         mag_b    <= in_mag_b;
         sign_a   <= in_sa;
         sign_b   <= in_sb;
         div_zero <= (DATA2 == 32'd0);
         ovf      <= is_div && !FUNC[0] && (DATA1 == 32'h8000_0000) && (DATA2 == 32'hFFFF_FFFF);
         prod     <= {32'd0, in_mag_b};
         rem      <= 32'd0;
         quo      <= in_mag_a;
      end else if (state == CALC && !FLUSH) begin
         if (cnt != 5'd0) cnt <= cnt - 5'd1;
         if (func_q[2]) begin
            rem <= rem_ge ? rem_sub[31:0] : rem_sh[31:0];
            quo <= {quo[30:0], rem_ge};
         end else begin
            prod <= prod_nxt;
         end
      end else if (state == FIX && !FLUSH) begin
         RESULT <= fix_res;
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, sign handling, special cases, flush and reset.
module tb_mul_div_unit;

   logic        CLK, RESET;
   logic [31:0] DATA1, DATA2;
   logic [2:0]  FUNC;
   logic        START, FLUSH;
   logic [31:0] RESULT;
   logic        BUSY, DONE;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] last_res = 32'd0;

   localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011,
                          F_DIV = 3'b100, F_DIVU = 3'b101, F_REM  = 3'b110, F_REMU  = 3'b111;

   mul_div_unit dut (
      .CLK(CLK), .RESET(RESET), .DATA1(DATA1), .DATA2(DATA2), .FUNC(FUNC),
      .START(START), .FLUSH(FLUSH), .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Call #1 after a rising edge (or mid-cycle); START is sampled at the next edge (t0).
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      int lat;
      bit busy_ok;
      DATA1 = a; DATA2 = b; FUNC = f; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      DATA1 = $urandom; DATA2 = $urandom; FUNC = 3'($urandom_range(0, 7));
      check_eq({tag, "_busy_t0"}, {31'd0, BUSY}, 32'd1);
      lat = 0; busy_ok = 1'b1;
      while (!DONE && lat < 40) begin
         if (!BUSY) busy_ok = 1'b0;
         @(posedge CLK); #1;
         lat++;
      end
      check_eq({tag, "_latency"}, 32'(lat), 32'd33);
      check_eq({tag, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
      check_eq({tag, "_busy_at_done"}, {31'd0, BUSY}, 32'd0);
      check_eq({tag, "_result"}, RESULT, exp);
      last_res = exp;
      @(posedge CLK); #1;
      check_eq({tag, "_done_pulse"}, {31'd0, DONE}, 32'd0);
      check_eq({tag, "_result_hold"}, RESULT, exp);
   endtask

   initial begin
      int dones;
      RESET = 1'b0; START = 1'b0; FLUSH = 1'b0; FUNC = 3'd0; DATA1 = 32'd0; DATA2 = 32'd0;
      #1;
      check_eq("rst_result", RESULT, 32'd0);
      check_eq("rst_busy", {31'd0, BUSY}, 32'd0);
      check_eq("rst_done", {31'd0, DONE}, 32'd0);
      repeat (2) @(posedge CLK);
      @(negedge CLK); RESET = 1'b1;

      // first START lands on the first rising edge after reset release
      run_op("mul_7_m3",     F_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
      run_op("mulh_min",     F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      run_op("mulhu_min",    F_MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      run_op("mulhsu_min",   F_MULHSU, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000);
      run_op("mulhu_ones",   F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_op("divu_by0",     F_DIVU,   32'd100,       32'd0,         32'hFFFF_FFFF);
      run_op("remu_by0",     F_REMU,   32'd100,       32'd0,         32'h0000_0064);
      run_op("div_by0_neg",  F_DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF);
      run_op("rem_by0_neg",  F_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9);
      run_op("div_m7_2",     F_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
      run_op("rem_m7_2",     F_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
      run_op("div_7_m2",     F_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD);
      run_op("rem_7_m2",     F_REM,    32'd7,         32'hFFFF_FFFE, 32'h0000_0001);
      run_op("div_ovf",      F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      run_op("rem_ovf",      F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
      run_op("divu_ovf_ops", F_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
      run_op("divu_100_7",   F_DIVU,   32'd100,       32'd7,         32'd14);
      run_op("remu_100_7",   F_REMU,   32'd100,       32'd7,         32'd2);

      // flush mid-operation: START at t0, FLUSH sampled at t10, restart at t12
      DATA1 = 32'd1000; DATA2 = 32'd3; FUNC = F_DIVU; START = 1'b1;
      @(posedge CLK); #1; START = 1'b0;
      repeat (9) @(posedge CLK);
      #1; FLUSH = 1'b1;
      @(posedge CLK); #1; FLUSH = 1'b0;
      check_eq("flush_busy", {31'd0, BUSY}, 32'd0);
      check_eq("flush_done", {31'd0, DONE}, 32'd0);
      check_eq("flush_result", RESULT, last_res);
      @(posedge CLK); #1;
      check_eq("flush_idle_t11", {31'd0, BUSY | DONE}, 32'd0);
      run_op("after_flush", F_DIVU, 32'd1000, 32'd3, 32'd333);

      // FLUSH beats START in IDLE
      DATA1 = 32'd5; DATA2 = 32'd5; FUNC = F_MUL; START = 1'b1; FLUSH = 1'b1;
      @(posedge CLK); #1; START = 1'b0; FLUSH = 1'b0;
      check_eq("flush_vs_start_busy", {31'd0, BUSY}, 32'd0);
      @(posedge CLK); #1;
      check_eq("flush_vs_start_idle", {31'd0, BUSY | DONE}, 32'd0);
      check_eq("flush_vs_start_res", RESULT, last_res);

      // START held high throughout: only the first operands count, DONE_ST ignores START
      DATA1 = 32'd7; DATA2 = 32'hFFFF_FFFD; FUNC = F_MUL; START = 1'b1;
      @(posedge CLK); #1;
      dones = 0;
      for (int k = 0; k < 40 && dones == 0; k++) begin
         DATA1 = $urandom; DATA2 = $urandom; FUNC = 3'($urandom_range(0, 7));
         @(posedge CLK); #1;
         if (DONE) begin
            dones++;
            check_eq("held_start_latency", 32'(k + 1), 32'd33);
         end
      end
      check_eq("held_start_done_seen", 32'(dones), 32'd1);
      check_eq("held_start_result", RESULT, 32'hFFFF_FFEB);
      last_res = 32'hFFFF_FFEB;
      @(posedge CLK); #1;
      START = 1'b0;
      check_eq("start_in_done_st", {31'd0, BUSY}, 32'd0);
      dones = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge CLK); #1;
         if (DONE || BUSY) dones++;
      end
      check_eq("held_start_no_extra", 32'(dones), 32'd0);

      // asynchronous reset mid-CALC
      DATA1 = 32'd123; DATA2 = 32'd4; FUNC = F_DIVU; START = 1'b1;
      @(posedge CLK); #1; START = 1'b0;
      repeat (5) @(posedge CLK);
      @(negedge CLK); #2;
      RESET = 1'b0;
      #1;
      check_eq("async_rst_result", RESULT, 32'd0);
      check_eq("async_rst_busy", {31'd0, BUSY}, 32'd0);
      check_eq("async_rst_done", {31'd0, DONE}, 32'd0);
      repeat (2) @(posedge CLK);
      @(negedge CLK); RESET = 1'b1;
      dones = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge CLK); #1;
         if (DONE || BUSY) dones++;
      end
      check_eq("rst_discard_no_done", 32'(dones), 32'd0);
      check_eq("rst_result_kept_zero", RESULT, 32'd0);
      @(negedge CLK);
      run_op("after_reset", F_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
      run_op("mulh_after", F_MULH, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
